joypad_reader: RTL
==================

JOYPAD_READER -- requirements
Module: joypad_reader

Interface
REQ-001 SHALL have parameter LATCH_CYCLES, default 600, latch pulse width in clocks (12 us at 50 MHz).
REQ-002 SHALL have parameter HALF_CYCLES, default 300, pad_clk high time and low time in clocks (6 us).
REQ-003 SHALL have parameter POLL_CYCLES, default 833333, auto-poll period in clocks (about 60 Hz).
REQ-004 SHALL have port CLOCK_50  input  1  system clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port poll_req  input  1  one-cycle request for an immediate poll.
REQ-007 SHALL have port pad_data_n  input  1  serial data from the controller, low = pressed, asynchronous.
REQ-008 SHALL have port pad_latch  output  1  latch strobe to the controller, active-high.
REQ-009 SHALL have port pad_clk  output  1  shift clock to the controller, active-high pulses.
REQ-010 SHALL have port buttons  output  8  last accepted frame, active-high; bits 0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-011 SHALL have port buttons_valid  output  1  one-cycle pulse when buttons updates.
REQ-012 SHALL have port busy  output  1  high while a poll is in progress (any state other than IDLE).

Function
REQ-013 SHALL pass pad_data_n through a 2-flop synchronizer before any use.
REQ-014 SHALL implement FSM states IDLE, LATCH, LOW, HIGH and DONE.
REQ-015 IDLE -> LATCH SHALL occur on the edge after a trigger, where a trigger is a poll_req or a poll-timer wrap; pad_latch rises on that edge.
REQ-016 LATCH SHALL hold pad_latch=1 for exactly LATCH_CYCLES clocks, then go to LOW.
REQ-017 LOW SHALL hold pad_clk=0 for HALF_CYCLES clocks and, on its last cycle, shift the inverted synchronized data into bit k (k=0..7, LSB first).
REQ-018 After a LOW phase: k<7 SHALL go to HIGH with k+1; k=7 SHALL go to DONE.
REQ-019 HIGH SHALL hold pad_clk=1 for HALF_CYCLES clocks, then go to LOW.
REQ-020 A poll SHALL produce exactly 7 pad_clk pulses, so pad_latch rise to DONE takes LATCH_CYCLES + 15*HALF_CYCLES clocks (5100 with defaults).
REQ-021 DONE SHALL last one cycle, load buttons, pulse buttons_valid, and return to IDLE.
REQ-022 The poll timer SHALL free-run from 0 to POLL_CYCLES-1 and wrap regardless of FSM state.
REQ-023 Triggers arriving while busy=1 SHALL be dropped, not queued.
REQ-024 A simultaneous poll_req and timer wrap SHALL start exactly one poll.
REQ-025 pad_latch and pad_clk SHALL never be high in the same cycle.

Reset
REQ-026 Reset SHALL force FSM=IDLE, poll timer=0, k=0, shift register=0, buttons=0, buttons_valid=0, busy=0, pad_latch=0 and pad_clk=0, all asynchronously.
REQ-027 Reset during a poll SHALL abort it with no buttons_valid pulse; a new poll starts only on a trigger after reset deasserts.

Configuration
REQ-028 With JOYPAD_DEBOUNCE_EN defined, DONE SHALL update buttons and pulse buttons_valid only when the new frame equals the previous raw frame (stored in a register cleared by reset).
REQ-029 Without JOYPAD_DEBOUNCE_EN, every DONE SHALL update buttons and pulse buttons_valid.

Structure
REQ-030 The FSM state enum and the button bit-index constants (BTN_A=0 ... BTN_RIGHT=7) SHALL live in shared package nes_pkg.
REQ-031 The input synchronizer SHALL be one sub-module, sync_2ff.

Verification
REQ-032 Pad model with A and Start pressed, then poll_req -> one latch of 600 clocks, 7 pad_clk pulses of 300 high / 300 low, buttons=8'h09, buttons_valid high for one cycle 5100 clocks after latch rise.
REQ-033 No poll_req, POLL_CYCLES=10000 -> latch rises every 10000 clocks; buttons_valid count equals latch count.
REQ-034 poll_req pulsed during READ plus a timer wrap while busy -> no extra latch until the next trigger after IDLE.
REQ-035 Reset asserted in the 4th HIGH phase -> pad_clk=0 and pad_latch=0 immediately, buttons=0, no buttons_valid pulse.
REQ-036 JOYPAD_DEBOUNCE_EN defined, frames 8'h01, 8'h01, 8'h02 -> first buttons_valid on frame 2 (buttons=8'h01), none on frame 3.
REQ-037 Assertion over all tests: pad_latch and pad_clk never high together.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES controller definitions: reader FSM states and button bit positions.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } joy_state_t;

  localparam int unsigned NUM_BUTTONS = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/joypad_reader.sv
// NES joypad poller: latch pulse, 7 shift clocks, 8 serial bits LSB first.
// Define JOYPAD_DEBOUNCE_EN to accept a frame only when it repeats the previous raw frame.
module joypad_reader
  import nes_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned POLL_CYCLES  = 833333
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       poll_req,
  input  logic       pad_data_n,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int unsigned TW        = cnt_width(POLL_CYCLES);
  localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned CW        = cnt_width(PHASE_MAX);

  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);

  joy_state_t             r_state;
  joy_state_t             w_state_next;
  logic [TW-1:0]          r_timer;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_next;
  logic [2:0]             r_bit;
  logic [2:0]             w_bit_next;
  logic [NUM_BUTTONS-1:0] r_shift;
  logic [NUM_BUTTONS-1:0] w_shift_next;
  logic [NUM_BUTTONS-1:0] r_buttons;
  logic                   r_valid;
  logic                   r_latch;
  logic                   r_clk;
  logic                   r_busy;
  logic                   w_load;
  logic                   w_data_n;
  logic                   w_wrap;
  logic                   w_trigger;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [NUM_BUTTONS-1:0] r_prev_raw;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (CLOCK_50),
    .i_rst (reset),
    .i_d   (pad_data_n),
    .o_q   (w_data_n)
  );

  assign w_wrap    = (r_timer == TIMER_LAST);
  assign w_trigger = poll_req | w_wrap;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)       r_timer <= '0;
    else if (w_wrap) r_timer <= '0;
    else             r_timer <= r_timer + 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_load       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_trigger) begin
          w_state_next = ST_LATCH;
          w_bit_next   = 3'(BTN_A);
        end
      end
      ST_LATCH: begin
        if (r_cnt == LATCH_LAST) begin
          w_state_next = ST_LOW;
          w_cnt_next   = '0;
        end
      end
      ST_LOW: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next            = '0;
          w_shift_next[r_bit]   = ~w_data_n;
          if (r_bit == 3'(BTN_RIGHT)) begin
            w_state_next = ST_DONE;
            w_load       = 1'b1;
          end else begin
            w_state_next = ST_HIGH;
            w_bit_next   = r_bit + 3'd1;
          end
        end
      end
      ST_HIGH: begin
        if (r_cnt == HALF_LAST) begin
          w_state_next = ST_LOW;
          w_cnt_next   = '0;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so the pad sees glitch-free edges.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_latch <= 1'b0;
      r_clk   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_latch <= (w_state_next == ST_LATCH);
      r_clk   <= (w_state_next == ST_HIGH);
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  // Frame is captured on entry to DONE so buttons and buttons_valid coincide with that cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_buttons  <= '0;
      r_valid    <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
      r_prev_raw <= '0;
`endif
    end else begin
`ifdef JOYPAD_DEBOUNCE_EN
      r_valid <= 1'b0;
      if (w_load) begin
        r_prev_raw <= w_shift_next;
        if (w_shift_next == r_prev_raw) begin
          r_buttons <= w_shift_next;
          r_valid   <= 1'b1;
        end
      end
`else
      r_valid <= w_load;
      if (w_load) r_buttons <= w_shift_next;
`endif
    end
  end

  assign pad_latch     = r_latch;
  assign pad_clk       = r_clk;
  assign busy          = r_busy;
  assign buttons       = r_buttons;
  assign buttons_valid = r_valid;

endmodule
